rgb_fade_arbiter: RTL and testbench

RGB_FADE_ARBITER -- requirements
Module: rgb_fade_arbiter

---
 rtl/rgb_fade_arbiter_pkg.sv | 38 +++
 rtl/pwm_channel.sv | 38 +++
 rtl/rgb_fade_arbiter.sv | 174 +++++++++++++++++
 tb/tb_rgb_fade_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_fade_arbiter_pkg.sv
// Shared types and constants for the RGB fade arbiter: FSM states, source IDs,
// PWM width and the duty scaling helper.
package rgb_fade_arbiter_pkg;

    localparam int PWM_BITS = 8;

    typedef enum logic [1:0] {
        BREATHE  = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2,
        HOLD     = 2'd3
    } fade_state_e;

    typedef enum logic [1:0] {
        SRC_REQ0 = 2'd0,
        SRC_REQ1 = 2'd1,
        SRC_IDLE = 2'd2
    } src_e;

    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
    localparam logic [PWM_BITS-1:0] LEVEL_MIN = '0;
    localparam logic                DIR_UP    = 1'b1;
    localparam logic                DIR_DOWN  = 1'b0;

    // Scale one colour channel by brightness: (ch * (level + 1)) >> 8.
    // level 255 returns ch unchanged, level 0 returns 0 for any ch.
    function automatic logic [PWM_BITS-1:0] scale_duty(
        input logic [PWM_BITS-1:0] ch,
        input logic [PWM_BITS-1:0] level
    );
        logic [PWM_BITS:0]     lvl_p1;
        logic [2*PWM_BITS-1:0] prod;
        lvl_p1 = {1'b0, level} + 9'd1;
        prod   = {8'd0, ch} * {7'd0, lvl_p1};
        return prod[2*PWM_BITS-1:PWM_BITS];
    endfunction

endpackage : rgb_fade_arbiter_pkg

// File: rtl/pwm_channel.sv
// One PWM channel: frame-aligned duty register, compare against the shared
// PWM counter, registered output.
module pwm_channel
    import rgb_fade_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    input  logic [PWM_BITS-1:0] duty_i,
    output logic                pwm_o
);

    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                pwm_q, pwm_d;
    logic                frame_end;

    // Duty only reloads on the last count of a frame so a frame never
    // changes width part-way through; the compare uses the held duty.
    always_comb begin
        frame_end = (pwm_cnt_i == LEVEL_MAX);
        duty_d    = frame_end ? duty_i : duty_q;
        pwm_d     = (pwm_cnt_i < duty_q);
    end

    // Duty and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule : pwm_channel

// File: rtl/rgb_fade_arbiter.sv
// Two-requester RGB LED arbiter. Ownership changes are hidden behind a
// fade-out / fade-in of the brightness level; with no requester the LED
// breathes the idle colour. req*_valid are level requests with no ready:
// grant reports which source currently owns the LED.
module rgb_fade_arbiter
    import rgb_fade_arbiter_pkg::*;
#(
    parameter int unsigned FADE_DIV   = 4096,
    parameter logic [23:0] IDLE_COLOR = 24'h000040
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [23:0]         req0_color,
    input  logic                req1_valid,
    input  logic [23:0]         req1_color,
    output logic                pwm_r,
    output logic                pwm_g,
    output logic                pwm_b,
    output logic [1:0]          grant,
    output logic                busy,
    output fade_state_e         dbg_state_o,
    output logic [PWM_BITS-1:0] dbg_level_o
);

    localparam int unsigned DIV_W = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV - 1);

    fade_state_e         state_q, state_d;
    src_e                cur_src_q, cur_src_d;
    src_e                sel;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic                dir_q, dir_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                step;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [1:0]          grant_q, grant_d;
    logic                busy_q, busy_d;
    logic [23:0]         active_color;
    logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;

    // Priority source select and the free-running step / PWM counters.
    always_comb begin
        if (req0_valid)      sel = SRC_REQ0;
        else if (req1_valid) sel = SRC_REQ1;
        else                 sel = SRC_IDLE;
        step      = (div_cnt_q == DIV_LAST);
        div_cnt_d = step ? '0 : div_cnt_q + DIV_W'(1);
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    end

    // State register: FSM, level, direction, counters and output decodes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BREATHE;
            cur_src_q <= SRC_IDLE;
            level_q   <= '0;
            dir_q     <= DIR_UP;
            div_cnt_q <= '0;
            pwm_cnt_q <= '0;
            grant_q   <= 2'b00;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_src_q <= cur_src_d;
            level_q   <= level_d;
            dir_q     <= dir_d;
            div_cnt_q <= div_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state: a source mismatch outside FADE_OUT starts a fade-out with
    // the level held that cycle; everything else moves only on step. FADE_OUT
    // never restarts and latches whichever source is selected at level 0.
    always_comb begin
        state_d   = state_q;
        cur_src_d = cur_src_q;
        level_d   = level_q;
        dir_d     = dir_q;
        if ((state_q != FADE_OUT) && (sel != cur_src_q)) begin
            state_d = FADE_OUT;
        end else if (step) begin
            unique case (state_q)
                BREATHE: begin
                    if (dir_q == DIR_UP) begin
                        if (level_q == LEVEL_MAX) dir_d   = DIR_DOWN;
                        else                      level_d = level_q + 8'd1;
                    end else begin
                        if (level_q == LEVEL_MIN) dir_d   = DIR_UP;
                        else                      level_d = level_q - 8'd1;
                    end
                end
                FADE_OUT: begin
                    if (level_q == LEVEL_MIN) begin
                        cur_src_d = sel;
                        state_d   = FADE_IN;
                    end else begin
                        level_d = level_q - 8'd1;
                    end
                end
                FADE_IN: begin
                    if (level_q == LEVEL_MAX) begin
                        if (cur_src_q != SRC_IDLE) begin
                            state_d = HOLD;
                        end else begin
                            state_d = BREATHE;
                            dir_d   = DIR_DOWN;
                        end
                    end else begin
                        level_d = level_q + 8'd1;
                    end
                end
                HOLD: begin
                    level_d = LEVEL_MAX;
                end
                default: begin
                    state_d = BREATHE;
                end
            endcase
        end
    end

    // Outputs: grant/busy decoded from the next state so the registered
    // copies line up with cur_src/state; duties from the live owner colour.
    always_comb begin
        busy_d = (state_d == FADE_OUT) || (state_d == FADE_IN);
        unique case (cur_src_d)
            SRC_REQ0: grant_d = 2'b01;
            SRC_REQ1: grant_d = 2'b10;
            default:  grant_d = 2'b00;
        endcase
        unique case (cur_src_q)
            SRC_REQ0: active_color = req0_color;
            SRC_REQ1: active_color = req1_color;
            default:  active_color = IDLE_COLOR;
        endcase
        duty_r = scale_duty(active_color[23:16], level_q);
        duty_g = scale_duty(active_color[15:8],  level_q);
        duty_b = scale_duty(active_color[7:0],   level_q);
    end

    pwm_channel u_pwm_r (
        .clk       (clk),
        .rst       (rst),
        .pwm_cnt_i (pwm_cnt_q),
        .duty_i    (duty_r),
        .pwm_o     (pwm_r)
    );

    pwm_channel u_pwm_g (
        .clk       (clk),
        .rst       (rst),
        .pwm_cnt_i (pwm_cnt_q),
        .duty_i    (duty_g),
        .pwm_o     (pwm_g)
    );

    pwm_channel u_pwm_b (
        .clk       (clk),
        .rst       (rst),
        .pwm_cnt_i (pwm_cnt_q),
        .duty_i    (duty_b),
        .pwm_o     (pwm_b)
    );

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;
    assign dbg_level_o = level_q;

endmodule : rgb_fade_arbiter

// File: tb/tb_rgb_fade_arbiter.sv
// Bench for rgb_fade_arbiter: cycle-by-cycle comparison against a behavioural
// model of the fade/arbitration rules, plus directed checks on PWM widths.
module tb_rgb_fade_arbiter;
    import rgb_fade_arbiter_pkg::*;

    localparam int          DIV    = 4;
    localparam logic [23:0] IDLE_C = 24'h000040;

    // Model mode and source names.
    localparam int M_BREATHE = 0, M_OUT = 1, M_IN = 2, M_HOLD = 3;
    localparam int S_REQ0 = 0, S_REQ1 = 1, S_IDLE = 2;

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [23:0] req0_color, req1_color;
    logic        pwm_r, pwm_g, pwm_b;
    logic [1:0]  grant;
    logic        busy;
    fade_state_e dbg_state;
    logic [7:0]  dbg_level;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rgb_fade_arbiter #(.FADE_DIV(DIV), .IDLE_COLOR(IDLE_C)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_color  (req0_color),
        .req1_valid  (req1_valid),
        .req1_color  (req1_color),
        .pwm_r       (pwm_r),
        .pwm_g       (pwm_g),
        .pwm_b       (pwm_b),
        .grant       (grant),
        .busy        (busy),
        .dbg_state_o (dbg_state),
        .dbg_level_o (dbg_level)
    );

    // ---------------- scoreboard counters ----------------
    int n_vectors;
    int n_miscompares;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_state, m_cur, m_level, m_dir, m_cyc;
    int m_duty[3];
    int m_pwm[3];

    function automatic int color_of(input int src);
        if (src == S_REQ0) return int'(req0_color);
        if (src == S_REQ1) return int'(req1_color);
        return int'(IDLE_C);
    endfunction

    function automatic int state_code(input int s);
        case (s)
            M_OUT:   return int'(FADE_OUT);
            M_IN:    return int'(FADE_IN);
            M_HOLD:  return int'(HOLD);
            default: return int'(BREATHE);
        endcase
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        int sel, p, col;
        bit stp;
        if (rst) begin
            m_state = M_BREATHE; m_cur = S_IDLE; m_level = 0; m_dir = 1; m_cyc = 0;
            for (int c = 0; c < 3; c++) begin m_duty[c] = 0; m_pwm[c] = 0; end
            return;
        end
        sel = req0_valid ? S_REQ0 : (req1_valid ? S_REQ1 : S_IDLE);
        stp = ((m_cyc % DIV) == DIV - 1);
        p   = m_cyc % 256;
        for (int c = 0; c < 3; c++) m_pwm[c] = (p < m_duty[c]) ? 1 : 0;
        if (p == 255) begin
            col = color_of(m_cur);
            for (int c = 0; c < 3; c++)
                m_duty[c] = (((col >> (16 - 8 * c)) & 255) * (m_level + 1)) >> 8;
        end
        if (m_state != M_OUT && sel != m_cur) begin
            m_state = M_OUT;
        end else if (stp) begin
            if (m_state == M_BREATHE) begin
                if (m_dir == 1) begin
                    if (m_level == 255) m_dir = 0; else m_level++;
                end else begin
                    if (m_level == 0) m_dir = 1; else m_level--;
                end
            end else if (m_state == M_OUT) begin
                if (m_level == 0) begin m_cur = sel; m_state = M_IN; end
                else m_level--;
            end else if (m_state == M_IN) begin
                if (m_level == 255) begin
                    if (m_cur != S_IDLE) m_state = M_HOLD;
                    else begin m_state = M_BREATHE; m_dir = 0; end
                end else m_level++;
            end
        end
        m_cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        int exp_grant;
        if (n_miscompares >= 40) return;
        model_step();
        @(posedge clk);
        #1;
        exp_grant = (m_cur == S_REQ0) ? 1 : ((m_cur == S_REQ1) ? 2 : 0);
        check_eq("grant",   grant, exp_grant);
        check_eq("busy",    busy, (m_state == M_OUT || m_state == M_IN) ? 1 : 0);
        check_eq("pwm_rgb", {pwm_r, pwm_g, pwm_b}, {m_pwm[0][0], m_pwm[1][0], m_pwm[2][0]});
        check_eq("state",   dbg_state, state_code(m_state));
        check_eq("level",   dbg_level, m_level);
    endtask

    task automatic run_until_state(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (m_state != target && n < budget) begin tick(); n++; end
        check_eq(tag, dbg_state, state_code(target));
    endtask

    task automatic count_high(input int ch, input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            cnt += (ch == 0) ? int'(pwm_r) : ((ch == 1) ? int'(pwm_g) : int'(pwm_b));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt, n, hold_n;
        n_vectors = 0; n_miscompares = 0;
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_color = 24'h0; req1_color = 24'h0;
        tick(); tick();
        check_eq("rst_grant", grant, 0);
        check_eq("rst_pwm",   {pwm_r, pwm_g, pwm_b}, 0);
        rst = 1'b0;

        // Idle breathing on the idle colour.
        for (int i = 0; i < 8200; i++) tick();
        check_eq("idle_grant", grant, 0);

        // From idle at level 0, requester 1 red.
        n = 0;
        while (!(m_state == M_BREATHE && m_level == 0) && n < 2200) begin tick(); n++; end
        check_eq("idle_level0", dbg_level, 0);
        req1_valid = 1'b1; req1_color = 24'hFF0000;
        tick();
        check_eq("req1_busy", busy, 1);
        run_until_state(M_HOLD, 1200, "req1_hold");
        check_eq("req1_grant", grant, 2'b10);
        for (int i = 0; i < 300; i++) tick();
        count_high(0, 256, cnt); check_eq("req1_r_width", cnt, 255);
        count_high(1, 256, cnt); check_eq("req1_g_width", cnt, 0);

        // Pre-empt with requester 0 green.
        req0_valid = 1'b1; req0_color = 24'h00FF00;
        run_until_state(M_IN, 1200, "req0_fadein");
        check_eq("req0_grant", grant, 2'b01);
        run_until_state(M_HOLD, 1200, "req0_hold");
        for (int i = 0; i < 300; i++) tick();
        count_high(1, 256, cnt); check_eq("req0_g_width", cnt, 255);

        // Fade-out toward req1, which drops and returns before level 0.
        req1_color = 24'($urandom);
        req0_valid = 1'b0;
        n = 0;
        while (!(m_state == M_OUT && m_level < 200) && n < 400) begin tick(); n++; end
        req1_valid = 1'b0;
        hold_n = $urandom_range(20, 100);
        for (int i = 0; i < hold_n; i++) tick();
        check_eq("drop_no_restart", dbg_state, FADE_OUT);
        req1_valid = 1'b1;
        run_until_state(M_HOLD, 2500, "bounce_hold");
        check_eq("bounce_grant", grant, 2'b10);

        // Mid-frame colour change in HOLD: width changes only from next frame.
        req1_color = 24'hFF0000;
        for (int i = 0; i < 600; i++) tick();
        n = 0;
        while ((m_cyc % 256) != 100 && n < 300) begin tick(); n++; end
        req1_color = 24'h100000;
        count_high(0, 150, cnt); check_eq("midframe_old_width", cnt, 150);
        for (int i = 0; i < 300; i++) tick();
        count_high(0, 256, cnt); check_eq("midframe_new_width", cnt, 16);

        // Reset during FADE_IN at level 128, then re-arbitration.
        req0_valid = 1'b1; req0_color = 24'($urandom);
        n = 0;
        while (!(m_state == M_IN && m_level == 128) && n < 3000) begin tick(); n++; end
        check_eq("pre_rst_level", dbg_level, 128);
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("rst_mid_pwm",   {pwm_r, pwm_g, pwm_b}, 0);
        check_eq("rst_mid_grant", grant, 0);
        check_eq("rst_mid_busy",  busy, 0);
        check_eq("rst_mid_state", dbg_state, BREATHE);
        check_eq("rst_mid_level", dbg_level, 0);
        run_until_state(M_HOLD, 2000, "rearb_hold");
        check_eq("rearb_grant", grant, 2'b01);

        // Randomized requests and colours.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req1_valid = 1'($urandom_range(0, 1));
                req0_color = 24'($urandom);
                req1_color = 24'($urandom);
            end
            rst = ($urandom_range(0, 2999) == 0);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_rgb_fade_arbiter
